// File: rtl/nnet_framer_pkg.sv
// Shared CHDR tuser field offsets, FSM state types and helpers for the
// nnet stream framer.
package nnet_framer_pkg;

  localparam int unsigned TUSER_W     = 128;
  localparam int unsigned SIZE_W      = 16;
  localparam int unsigned TU_HAS_TIME = 125;
  localparam int unsigned TU_LEN_LSB  = 96;
  localparam int unsigned TU_SRC_LSB  = 80;
  localparam int unsigned TU_DST_LSB  = 64;

  localparam logic [SIZE_W-1:0] HDR_LEN_BASE = 16'd8;
  localparam logic [SIZE_W-1:0] HDR_LEN_TIME = 16'd16;

  typedef enum logic [1:0] {IN_IDLE, IN_PASS, IN_PAD, IN_DROP} in_state_e;
  typedef enum logic {OUT_IDLE, OUT_RUN} out_state_e;

  // A programmed size of zero means a one-sample vector.
  function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] s);
    return (s == '0) ? 16'd1 : s;
  endfunction

  function automatic logic [SIZE_W-1:0] sat_inc(input logic [SIZE_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nnet_hdr_fifo.sv
// Header FIFO holding one CHDR tuser word per packet in flight between the
// input framer and the output framer.
module nnet_hdr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nnet_stream_framer.sv
// Frames a CHDR sample stream into fixed-length HLS vectors (pad/truncate)
// and reframes the HLS result stream with a rewritten CHDR header.
module nnet_stream_framer
  import nnet_framer_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BUS_W     = 32,
  parameter int unsigned HDR_DEPTH = 4,
  parameter int unsigned SIGN_EXT  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [15:0]        next_dst_sid,
  input  logic [15:0]        pkt_size_in,
  input  logic [15:0]        pkt_size_out,
  input  logic [BUS_W-1:0]   i_tdata,
  input  logic [127:0]       i_tuser,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [BUS_W-1:0]   o_tdata,
  output logic [127:0]       o_tuser,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic [BUS_W-1:0]   m_axis_data_tdata,
  output logic               m_axis_data_tlast,
  output logic               m_axis_data_tvalid,
  input  logic               m_axis_data_tready,
  input  logic [BUS_W-1:0]   s_axis_data_tdata,
  input  logic               s_axis_data_tvalid,
  output logic               s_axis_data_tready,
  output logic [15:0]        pad_count,
  output logic [15:0]        trunc_count
);

  in_state_e     in_state, in_state_nxt;
  out_state_e    out_state, out_state_nxt;
  logic [15:0]   in_cnt, in_cnt_nxt, size_in, size_in_nxt, in_size;
  logic [15:0]   out_cnt, out_cnt_nxt, size_out, size_out_nxt;
  logic [15:0]   pad_nxt, trunc_nxt;
  logic          in_at_last, in_beat, out_at_last, flush;
  logic          hdr_push, hdr_pop, hdr_full, hdr_empty;
  logic [127:0]  hdr_rdata;
  logic          s_tdata_unused;

  assign flush = clear || !reset_n;

  nnet_hdr_fifo #(.DEPTH(HDR_DEPTH), .W(TUSER_W)) u_hdr_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .push   (hdr_push),
    .wdata  (i_tuser),
    .pop    (hdr_pop),
    .rdata  (hdr_rdata),
    .full   (hdr_full),
    .empty  (hdr_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state    <= IN_IDLE;
      in_cnt      <= '0;
      size_in     <= 16'd1;
      out_state   <= OUT_IDLE;
      out_cnt     <= '0;
      size_out    <= 16'd1;
      pad_count   <= '0;
      trunc_count <= '0;
    end else begin
      in_state    <= in_state_nxt;
      in_cnt      <= in_cnt_nxt;
      size_in     <= size_in_nxt;
      out_state   <= out_state_nxt;
      out_cnt     <= out_cnt_nxt;
      size_out    <= size_out_nxt;
      pad_count   <= pad_nxt;
      trunc_count <= trunc_nxt;
    end
  end

  // Input framer: the first beat of a packet is forwarded straight from idle.
  always_comb begin
    in_state_nxt       = in_state;
    in_cnt_nxt         = in_cnt;
    size_in_nxt        = size_in;
    pad_nxt            = pad_count;
    trunc_nxt          = trunc_count;
    hdr_push           = 1'b0;
    in_beat            = 1'b0;
    i_tready           = 1'b0;
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast  = 1'b0;
    m_axis_data_tdata  = i_tdata;
    in_size            = (in_state == IN_IDLE) ? eff_size(pkt_size_in) : size_in;
    in_at_last         = (in_cnt == in_size - 16'd1);
    case (in_state)
      IN_IDLE: begin
        m_axis_data_tvalid = i_tvalid && !hdr_full;
        i_tready           = m_axis_data_tready && !hdr_full;
        if (i_tvalid && i_tready) begin
          hdr_push    = 1'b1;
          size_in_nxt = in_size;
          in_beat     = 1'b1;
        end
      end
      IN_PASS: begin
        m_axis_data_tvalid = i_tvalid;
        i_tready           = m_axis_data_tready;
        in_beat            = i_tvalid && m_axis_data_tready;
      end
      IN_PAD: begin
        m_axis_data_tvalid = 1'b1;
        m_axis_data_tdata  = '0;
        if (m_axis_data_tready) begin
          if (in_at_last) begin
            in_state_nxt = IN_IDLE;
            in_cnt_nxt   = '0;
          end else begin
            in_cnt_nxt = in_cnt + 16'd1;
          end
        end
      end
      IN_DROP: begin
        i_tready = 1'b1;
        if (i_tvalid && i_tlast) in_state_nxt = IN_IDLE;
      end
      default: in_state_nxt = IN_IDLE;
    endcase

    // Vector full and input tlast together is a clean packet end.
    if (in_beat) begin
      if (in_at_last) begin
        in_cnt_nxt = '0;
        if (i_tlast) begin
          in_state_nxt = IN_IDLE;
        end else begin
          in_state_nxt = IN_DROP;
          trunc_nxt    = sat_inc(trunc_count);
        end
      end else begin
        in_cnt_nxt = in_cnt + 16'd1;
        if (i_tlast) begin
          in_state_nxt = IN_PAD;
          pad_nxt      = sat_inc(pad_count);
        end else begin
          in_state_nxt = IN_PASS;
        end
      end
    end

    m_axis_data_tlast = m_axis_data_tvalid && in_at_last;
    if (flush) begin
      i_tready           = 1'b0;
      m_axis_data_tvalid = 1'b0;
      m_axis_data_tlast  = 1'b0;
      hdr_push           = 1'b0;
    end
    if (clear) begin
      in_state_nxt = IN_IDLE;
      in_cnt_nxt   = '0;
      pad_nxt      = '0;
      trunc_nxt    = '0;
    end
  end

  // Output framer: one header per size_out result beats.
  always_comb begin
    out_state_nxt      = out_state;
    out_cnt_nxt        = out_cnt;
    size_out_nxt       = size_out;
    hdr_pop            = 1'b0;
    o_tvalid           = 1'b0;
    o_tlast            = 1'b0;
    s_axis_data_tready = 1'b0;
    out_at_last        = (out_cnt == size_out - 16'd1);
    case (out_state)
      OUT_IDLE: begin
        if (!hdr_empty) begin
          out_state_nxt = OUT_RUN;
          out_cnt_nxt   = '0;
          size_out_nxt  = eff_size(pkt_size_out);
        end
      end
      OUT_RUN: begin
        o_tvalid           = s_axis_data_tvalid;
        s_axis_data_tready = o_tready;
        o_tlast            = s_axis_data_tvalid && out_at_last;
        if (s_axis_data_tvalid && o_tready) begin
          if (out_at_last) begin
            hdr_pop       = 1'b1;
            out_state_nxt = OUT_IDLE;
            out_cnt_nxt   = '0;
          end else begin
            out_cnt_nxt = out_cnt + 16'd1;
          end
        end
      end
      default: out_state_nxt = OUT_IDLE;
    endcase

    if (flush) begin
      o_tvalid           = 1'b0;
      o_tlast            = 1'b0;
      s_axis_data_tready = 1'b0;
      hdr_pop            = 1'b0;
    end
    if (clear) begin
      out_state_nxt = OUT_IDLE;
      out_cnt_nxt   = '0;
    end
  end

  generate
    if (SIGN_EXT != 0) begin : g_sext
      assign o_tdata = BUS_W'($signed(s_axis_data_tdata[DATA_W-1:0]));
    end else begin : g_zext
      assign o_tdata = BUS_W'(s_axis_data_tdata[DATA_W-1:0]);
    end
  endgenerate

  assign s_tdata_unused = ^s_axis_data_tdata[BUS_W-1:DATA_W];

  // Header rewrite: new length, incoming dst becomes src, new dst.
  always_comb begin
    o_tuser = hdr_rdata;
    o_tuser[TU_LEN_LSB +: 16] = (size_out << 2) +
                                (hdr_rdata[TU_HAS_TIME] ? HDR_LEN_TIME : HDR_LEN_BASE);
    o_tuser[TU_SRC_LSB +: 16] = hdr_rdata[TU_DST_LSB +: 16];
    o_tuser[TU_DST_LSB +: 16] = next_dst_sid;
  end

endmodule

// File: tb/tb_nnet_stream_framer.sv
// Scoreboard bench for nnet_stream_framer with a buffering HLS loopback model;
// a second instance with SIGN_EXT=0 shares all stimulus.
module tb_nnet_stream_framer;

  typedef struct packed { logic [15:0] d; logic last; } beat_t;
  typedef struct packed { logic [31:0] d; logic last; } mbeat_t;

  logic         clk, reset_n, clear;
  logic [15:0]  next_dst_sid, pkt_size_in, pkt_size_out;
  logic [31:0]  i_tdata;
  logic [127:0] i_tuser;
  logic         i_tlast, i_tvalid, i_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast, o_tvalid, o_tready;
  logic [31:0]  m_tdata;
  logic         m_tlast, m_tvalid, m_tready;
  logic [31:0]  s_tdata;
  logic         s_tvalid, s_tready;
  logic [15:0]  pad_count, trunc_count;

  logic [31:0]  z_o_tdata, z_m_tdata;
  logic [127:0] z_o_tuser;
  logic         z_i_tready, z_o_tlast, z_o_tvalid, z_m_tlast, z_m_tvalid, z_s_tready;
  logic [15:0]  z_pad, z_trunc;
  logic         z_unused;

  beat_t        exp_q[$];
  mbeat_t       m_exp_q[$];
  logic [127:0] hdr_q[$];
  logic [31:0]  hls_q[$];

  int n_tests = 0, n_fail = 0;
  int exp_pad = 0, exp_trunc = 0, first_acc = 0, cur_size = 8;
  bit o_hold = 1'b1;

  nnet_stream_framer #(.DATA_W(16), .BUS_W(32), .HDR_DEPTH(4), .SIGN_EXT(1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .next_dst_sid(next_dst_sid),
    .pkt_size_in(pkt_size_in), .pkt_size_out(pkt_size_out),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tlast(m_tlast), .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready),
    .pad_count(pad_count), .trunc_count(trunc_count)
  );

  nnet_stream_framer #(.DATA_W(16), .BUS_W(32), .HDR_DEPTH(4), .SIGN_EXT(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .clear(clear), .next_dst_sid(next_dst_sid),
    .pkt_size_in(pkt_size_in), .pkt_size_out(pkt_size_out),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(z_i_tready),
    .o_tdata(z_o_tdata), .o_tuser(z_o_tuser), .o_tlast(z_o_tlast), .o_tvalid(z_o_tvalid), .o_tready(o_tready),
    .m_axis_data_tdata(z_m_tdata), .m_axis_data_tlast(z_m_tlast), .m_axis_data_tvalid(z_m_tvalid),
    .m_axis_data_tready(m_tready),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(z_s_tready),
    .pad_count(z_pad), .trunc_count(z_trunc)
  );

  assign z_unused = ^{z_i_tready, z_o_tuser, z_o_tlast, z_o_tvalid, z_m_tdata,
                      z_m_tlast, z_m_tvalid, z_s_tready, z_pad, z_trunc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_hdr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // HLS stand-in: buffers every forwarded sample and returns it unchanged.
  initial begin
    mbeat_t mb;
    logic [31:0] md;
    logic ml;
    bit mhs, shs;
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    forever begin
      @(negedge clk);
      mhs = m_tvalid && m_tready;
      shs = s_tvalid && s_tready;
      md  = m_tdata;
      ml  = m_tlast;
      if (mhs) begin
        if (m_exp_q.size() == 0) check("m_extra_beat", 1, 0);
        else begin
          mb = m_exp_q.pop_front();
          check("m_tdata", md, mb.d);
          check("m_tlast", ml, mb.last);
        end
      end
      @(posedge clk);
      if (shs && hls_q.size() != 0) void'(hls_q.pop_front());
      if (mhs) hls_q.push_back(md);
      #1;
      m_tready = ($urandom_range(0, 4) != 0);
      s_tvalid = (hls_q.size() != 0);
      s_tdata  = (hls_q.size() != 0) ? hls_q[0] : 32'h0;
    end
  end

  // Output monitor: compares every accepted output beat with the scoreboard.
  initial begin
    beat_t b;
    o_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) check("o_extra_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("o_tdata_sext", o_tdata, {{16{b.d[15]}}, b.d});
          check("o_tdata_zext", z_o_tdata, {16'h0, b.d});
          check("o_tlast", o_tlast, b.last);
          if (hdr_q.size() == 0) check("o_hdr_missing", 1, 0);
          else begin
            check("o_tuser", o_tuser, hdr_q[0]);
            if (b.last) void'(hdr_q.pop_front());
          end
        end
      end
      @(posedge clk);
      #1 o_tready = o_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive_beat(input logic [31:0] d, input bit last, input logic [127:0] u, output bit to);
    bit ok;
    to = 1'b0;
    ok = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      i_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    i_tdata  = d;
    i_tuser  = u;
    i_tlast  = last;
    i_tvalid = 1'b1;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = i_tready;
    end
    if (!ok) begin
      check("beat_timeout", 0, 1);
      to = 1'b1;
      i_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int len, input logic [127:0] hdr, input bit use_8001);
    int n;
    logic [31:0] dat[$];
    mbeat_t mb;
    beat_t ob;
    logic [127:0] e;
    bit to;
    n = (cur_size == 0) ? 1 : cur_size;
    for (int b = 0; b < len; b++) dat.push_back((use_8001 && b == 0) ? 32'h5A5A8001 : $urandom);
    for (int k = 0; k < n; k++) begin
      mb.d    = (k < len) ? dat[k] : 32'h0;
      mb.last = (k == n - 1);
      m_exp_q.push_back(mb);
      ob.d    = mb.d[15:0];
      ob.last = mb.last;
      exp_q.push_back(ob);
    end
    e = hdr;
    e[111:96] = 16'(n * 4) + (hdr[125] ? 16'd16 : 16'd8);
    e[95:80]  = hdr[79:64];
    e[79:64]  = next_dst_sid;
    hdr_q.push_back(e);
    if (len < n) exp_pad++;
    else if (len > n) exp_trunc++;
    for (int b = 0; b < len; b++) begin
      drive_beat(dat[b], (b == len - 1), hdr, to);
      if (to) break;
      if (b == 0) first_acc++;
    end
    i_tvalid = 1'b0;
  endtask

  // Beats of a packet that will be abandoned; only the HLS side sees them.
  task automatic send_partial(input int nb);
    mbeat_t mb;
    logic [127:0] h;
    bit to;
    h = rand_hdr();
    for (int b = 0; b < nb; b++) begin
      mb.d    = $urandom;
      mb.last = 1'b0;
      m_exp_q.push_back(mb);
      drive_beat(mb.d, 1'b0, h, to);
    end
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(posedge clk);
      ok = (exp_q.size() == 0) && (m_exp_q.size() == 0) && (hdr_q.size() == 0);
    end
    if (!ok) check({tag, "_drain_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_pad_count"}, pad_count, 16'(exp_pad));
    check({tag, "_trunc_count"}, trunc_count, 16'(exp_trunc));
    @(posedge clk);
    #1;
  endtask

  task automatic set_size(input int s);
    cur_size     = s;
    pkt_size_in  = 16'(s);
    pkt_size_out = 16'(s);
  endtask

  task automatic flush_model();
    exp_q.delete();
    m_exp_q.delete();
    hdr_q.delete();
    hls_q.delete();
    exp_pad   = 0;
    exp_trunc = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_o_tvalid"}, o_tvalid, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_i_tready"}, i_tready, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_o_tlast"}, o_tlast, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    next_dst_sid = 16'h0A5C;
    i_tdata  = '0;
    i_tuser  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    set_size(8);
    #2;
    check_quiet("reset");
    check("reset_pad_count", pad_count, 0);
    check("reset_trunc_count", trunc_count, 0);
    i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    o_hold = 1'b0;

    // Exact-length packets, including the 0x8001 sign-extension sample.
    send_pkt(8, rand_hdr(), 1'b1);
    send_pkt(8, {2'b00, 1'b1, 125'(rand_hdr())}, 1'b0);
    send_pkt(8, {2'b00, 1'b0, 125'(rand_hdr())}, 1'b1);
    drain("exact8");

    send_pkt(5, rand_hdr(), 1'b0);
    drain("pad5of8");
    send_pkt(1, rand_hdr(), 1'b1);
    drain("pad1of8");

    set_size(4);
    send_pkt(10, rand_hdr(), 1'b0);
    drain("trunc10of4");
    send_pkt(4, rand_hdr(), 1'b0);
    drain("exact4");

    set_size(0);
    send_pkt(1, rand_hdr(), 1'b1);
    send_pkt(3, rand_hdr(), 1'b0);
    drain("size0");

    // Header FIFO back-pressure with the output stalled.
    set_size(4);
    o_hold = 1'b1;
    first_acc = 0;
    fork
      for (int p = 0; p < 6; p++) send_pkt(4, rand_hdr(), 1'b0);
    join_none
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("fifo_full_pkts_accepted", 32'(first_acc), 4);
    check("fifo_full_i_tready", i_tready, 0);
    @(posedge clk);
    #1 o_hold = 1'b0;
    wait fork;
    drain("six_pkts");

    // Reset in the middle of a packet.
    set_size(8);
    o_hold = 1'b1;
    send_partial(3);
    reset_n = 1'b0;
    #1;
    check_quiet("midpkt_reset");
    i_tvalid = 1'b0;
    flush_model();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    o_hold = 1'b0;
    send_pkt(8, rand_hdr(), 1'b0);
    drain("after_reset");

    // Clear in the middle of a packet also zeroes the event counters.
    send_pkt(5, rand_hdr(), 1'b0);
    drain("pad_before_clear");
    o_hold = 1'b1;
    send_partial(3);
    clear = 1'b1;
    #1;
    check_quiet("midpkt_clear");
    @(posedge clk);
    #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    flush_model();
    o_hold = 1'b0;
    send_pkt(8, rand_hdr(), 1'b1);
    drain("after_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nnet_stream_framer.md
NNET_STREAM_FRAMER -- requirements
Module: nnet_stream_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the significant sample width returned by the HLS core.
REQ-002 SHALL have parameter BUS_W, default 32, meaning the AXI data width on all four streams.
REQ-003 SHALL have parameter HDR_DEPTH, default 4 (power of two, at least 2), meaning header FIFO depth, i.e. the number of packets in flight.
REQ-004 SHALL have parameter SIGN_EXT, default 1, meaning output samples are sign-extended (1) or zero-extended (0) from DATA_W to BUS_W.
REQ-005 Ports: clk  in  1  sole clock; all logic is on its rising edge.
REQ-006 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Ports: clear  in  1  synchronous flush.
REQ-008 Ports: next_dst_sid  in  16  destination SID for output packets.
REQ-009 Ports: pkt_size_in / pkt_size_out  in  16 each  HLS vector lengths in samples.
REQ-010 Ports: i_tdata/i_tuser/i_tlast/i_tvalid/i_tready  BUS_W/128/1/1/out  sink from axi_wrapper.
REQ-011 Ports: o_tdata/o_tuser/o_tlast/o_tvalid/o_tready  BUS_W/128/1/1/in  source to axi_wrapper.
REQ-012 Ports: m_axis_data_* (tdata BUS_W, tlast, tvalid, tready in)  to the HLS core; s_axis_data_* (tdata BUS_W, tvalid, tready out)  from the HLS core.
REQ-013 Ports: pad_count, trunc_count  out  16 each  saturating event counters.

Function
REQ-014 Input FSM states SHALL be IN_IDLE, IN_PASS, IN_PAD and IN_DROP; the input size SHALL be latched from pkt_size_in on the first beat, with 0 treated as 1.
REQ-015 IN_IDLE: on the first i_tvalid beat, if the header FIFO is not full, push i_tuser and forward the beat, then go to IN_PASS; if the FIFO is full, hold i_tready=0.
REQ-016 IN_PASS forwarding SHALL be zero-latency: m_tdata=i_tdata, m_tvalid=i_tvalid, i_tready=m_tready, and m_tlast SHALL assert on beat index size_in-1.
REQ-017 If i_tlast arrives before index size_in-1, go to IN_PAD and drive zero beats (m_tvalid=1, i_tready=0) until size_in beats are emitted; pad_count SHALL increment by 1.
REQ-018 If size_in beats are emitted before i_tlast, go to IN_DROP, sink input with i_tready=1 and m_tvalid=0 through i_tlast, and increment trunc_count by 1.
REQ-019 When both conditions coincide (i_tlast on index size_in-1), the packet SHALL complete normally and neither counter SHALL change.
REQ-020 Output FSM states SHALL be OUT_IDLE and OUT_RUN; it SHALL leave OUT_IDLE when the header FIFO is non-empty, latching size_out (0 treated as 1).
REQ-021 OUT_RUN: o_tvalid=s_tvalid and s_tready=o_tready (zero latency); o_tlast SHALL assert on beat index size_out-1, which pops the header and returns to OUT_IDLE.
REQ-022 In OUT_IDLE s_tready SHALL be 0.
REQ-023 o_tdata SHALL be s_tdata[DATA_W-1:0] extended per SIGN_EXT.
REQ-024 o_tuser SHALL equal the popped header with these fields replaced:
  - [111:96] = 4*size_out+8, or +16 if has_time [125] is set;
  - [95:80] = input dst SID [79:64];
  - [79:64] = next_dst_sid.
  All other bits, including EOB and time, SHALL pass unchanged.
REQ-025 Beat counters SHALL be 16 bits with no wrap inside a packet, since size is at most 65535.
REQ-026 Counters SHALL saturate at 16'hFFFF.
REQ-027 A change to pkt_size_in or pkt_size_out mid-packet SHALL take effect only at the next packet.
REQ-028 clear SHALL return both FSMs to idle, empty the header FIFO and zero pad_count and trunc_count in one cycle; ready and valid outputs SHALL be 0 during that cycle.

Reset
REQ-029 reset_n low SHALL asynchronously force: both FSMs to idle, FIFO empty, all counters 0, and o_tvalid, m_tvalid, i_tready, s_tready, o_tlast and m_tlast to 0.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet; the first packet after deassertion SHALL be framed correctly.

Structure
REQ-031 Package nnet_framer_pkg SHALL hold the CHDR tuser field offsets, the FSM state enums and the header-length constants 8 and 16.
REQ-032 The header FIFO SHALL be a single sub-module nnet_hdr_fifo (128-bit wide, HDR_DEPTH deep, full/empty flags, synchronous clear).

Verification
REQ-033 pkt_size_in=8, 8-beat input packet, HLS loopback, pkt_size_out=8: 8 output beats, tlast on beat 8, length field 40, src/dst SIDs swapped or replaced, counters 0.
REQ-034 pkt_size_in=8, 5-beat input: 3 zero beats appended, m_tlast on the 8th beat, pad_count=1.
REQ-035 pkt_size_in=4, 10-beat input: 4 beats forwarded, 6 beats dropped with i_tready=1, trunc_count=1.
REQ-036 HDR_DEPTH=4, o_tready=0, six back-to-back packets: after 4 headers i_tready stays 0; after release all 6 packets are output in order with the correct tuser.
REQ-037 HLS returns 16'h8001 with SIGN_EXT=1: o_tdata=32'hFFFF8001; with SIGN_EXT=0: 32'h00008001.
REQ-038 reset_n pulsed low mid-packet, then clear pulsed mid-packet: outputs 0 immediately, then the next 8-beat packet is framed correctly.
